// File: rtl/piso_frame_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out frame serializer:
// FSM state encoding and a counter-width helper.
package piso_frame_serializer_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   // Counter width for n distinct values, never narrower than one bit.
   function automatic int cnt_width(input int n);
      if (n < 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable shift register with a serial tap; zeros are shifted in so the tap
// naturally falls to 0 once a full word has been shifted out.
module piso_shift_reg
   import piso_frame_serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             tap
);

   logic [WIDTH-1:0] sr_r;

   // Load has priority so a back-to-back reload wins over the final shift.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_r <= {WIDTH{1'b0}};
      end else if (load) begin
         sr_r <= din;
      end else if (shift) begin
         if (MSB_FIRST) begin
            sr_r <= {sr_r[WIDTH-2:0], 1'b0};
         end else begin
            sr_r <= {1'b0, sr_r[WIDTH-1:1]};
         end
      end else begin
         sr_r <= sr_r;
      end
   end

   assign tap = MSB_FIRST ? sr_r[WIDTH-1] : sr_r[0];

endmodule

// File: rtl/piso_frame_serializer.sv
// Frame serializer: accepts a word on a valid/ready handshake and emits it one
// bit per clock with bit-valid and end-of-frame strobes, plus an optional idle gap.
module piso_frame_serializer
   import piso_frame_serializer_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             d_out,
   output logic             d_out_valid,
   output logic             frame_done,
   output logic             busy
);

   localparam int              BW         = cnt_width(WIDTH);
   localparam logic [BW-1:0]   LAST_IDX   = BW'(WIDTH - 1);
   localparam logic [BW-1:0]   PENULT_IDX = BW'(WIDTH - 2);
   localparam logic [BW-1:0]   BIT_ONE    = BW'(1);
   localparam bit              NO_GAP     = (GAP_CYCLES == 0);

   logic [1:0]    state_r;
   logic [1:0]    next_state_s;
   logic [BW-1:0] bit_cnt_r;
   logic          rdy_en_r;
   logic          valid_r;
   logic          done_r;
   logic          accept_s;
   logic          last_bit_s;
   logic          shift_s;
   logic          gap_last_s;

   assign shift_s    = (state_r == ST_SHIFT);
   assign last_bit_s = shift_s && (bit_cnt_r == LAST_IDX);
   assign din_ready  = rdy_en_r & ((state_r == ST_IDLE) | (last_bit_s & NO_GAP));
   assign accept_s   = din_valid & din_ready;

   // Next-state selection for the IDLE/SHIFT/GAP sequencer.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) next_state_s = ST_SHIFT;
            else          next_state_s = ST_IDLE;
         end
         ST_SHIFT: begin
            if (!last_bit_s)  next_state_s = ST_SHIFT;
            else if (!NO_GAP) next_state_s = ST_GAP;
            else if (accept_s) next_state_s = ST_SHIFT;
            else              next_state_s = ST_IDLE;
         end
         ST_GAP: begin
            if (gap_last_s) next_state_s = ST_IDLE;
            else            next_state_s = ST_GAP;
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State, bit position and output strobes; rdy_en holds ready low for one cycle after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         bit_cnt_r <= {BW{1'b0}};
         rdy_en_r  <= 1'b0;
         valid_r   <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         rdy_en_r <= 1'b1;
         if (accept_s) begin
            bit_cnt_r <= {BW{1'b0}};
         end else if (shift_s && !last_bit_s) begin
            bit_cnt_r <= bit_cnt_r + BIT_ONE;
         end else begin
            bit_cnt_r <= {BW{1'b0}};
         end
         valid_r <= (next_state_s == ST_SHIFT);
         done_r  <= shift_s && (bit_cnt_r == PENULT_IDX);
      end
   end

   generate
      if (GAP_CYCLES > 0) begin : g_gap
         localparam int            GW       = cnt_width(GAP_CYCLES + 1);
         localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
         localparam logic [GW-1:0] GAP_ONE  = GW'(1);
         logic [GW-1:0] gap_cnt_r;

         // Idle-gap cycle counter, parked at zero outside GAP.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               gap_cnt_r <= {GW{1'b0}};
            end else if ((state_r == ST_GAP) && (gap_cnt_r != GAP_LAST)) begin
               gap_cnt_r <= gap_cnt_r + GAP_ONE;
            end else begin
               gap_cnt_r <= {GW{1'b0}};
            end
         end

         assign gap_last_s = (state_r == ST_GAP) && (gap_cnt_r == GAP_LAST);
      end else begin : g_no_gap
         assign gap_last_s = 1'b1;
      end
   endgenerate

   piso_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift_reg (
      .clk   (clk),
      .rst   (rst),
      .load  (accept_s),
      .shift (shift_s),
      .din   (din),
      .tap   (d_out)
   );

   assign d_out_valid = valid_r;
   assign frame_done  = done_r;
   assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Directed bench for piso_frame_serializer: three configurations (MSB-first,
// LSB-first, 3-cycle gap) plus a 10101 detector model chained on instance 0.
module tb_piso_frame_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] din_v [3];
   logic [2:0] din_valid_v;
   logic [2:0] din_ready_v;
   logic [2:0] d_out_v;
   logic [2:0] d_out_valid_v;
   logic [2:0] frame_done_v;
   logic [2:0] busy_v;
   int         checks   = 0;
   int         failures = 0;
   logic [3:0] hist  = 4'd0;
   logic       y_out = 1'b0;

   typedef struct {
      int         sel;
      logic [7:0] word;
      logic [7:0] bits;
      logic [8:0] ymask;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   piso_frame_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_msb (
      .clk(clk), .rst(rst), .din(din_v[0]), .din_valid(din_valid_v[0]),
      .din_ready(din_ready_v[0]), .d_out(d_out_v[0]), .d_out_valid(d_out_valid_v[0]),
      .frame_done(frame_done_v[0]), .busy(busy_v[0]));

   piso_frame_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_lsb (
      .clk(clk), .rst(rst), .din(din_v[1]), .din_valid(din_valid_v[1]),
      .din_ready(din_ready_v[1]), .d_out(d_out_v[1]), .d_out_valid(d_out_valid_v[1]),
      .frame_done(frame_done_v[1]), .busy(busy_v[1]));

   piso_frame_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) u_gap (
      .clk(clk), .rst(rst), .din(din_v[2]), .din_valid(din_valid_v[2]),
      .din_ready(din_ready_v[2]), .d_out(d_out_v[2]), .d_out_valid(d_out_valid_v[2]),
      .frame_done(frame_done_v[2]), .busy(busy_v[2]));

   // Overlapping 10101 detector with registered output, fed from instance 0.
   always @(posedge clk) begin
      hist  <= {hist[2:0], d_out_v[0]};
      y_out <= ({hist, d_out_v[0]} == 5'b10101);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; drives one word and checks all eight bit cycles.
   task automatic run_frame(input int sel, input logic [7:0] word, input logic [7:0] bits,
                            input logic [8:0] ymask, output int waits);
      logic [8:0] ym;
      ym = 9'd0;
      din_v[sel] = word;
      din_valid_v[sel] = 1'b1;
      waits = 0;
      while (din_ready_v[sel] !== 1'b1 && waits < 20) begin
         @(negedge clk);
         waits = waits + 1;
      end
      check("handshake_wait", (waits < 20), 1);
      @(negedge clk);
      din_valid_v[sel] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("bit%0d_w%0h", i, word), d_out_v[sel], bits[7-i]);
         check($sformatf("valid%0d_w%0h", i, word), d_out_valid_v[sel], 1);
         check($sformatf("done%0d_w%0h", i, word), frame_done_v[sel], (i == 7));
         ym[i] = y_out;
         @(negedge clk);
      end
      ym[8] = y_out;
      check($sformatf("post_valid_w%0h", word), d_out_valid_v[sel], 0);
      check($sformatf("post_dout_w%0h", word), d_out_v[sel], 0);
      if (sel == 0) check($sformatf("detector_w%0h", word), ym, ymask);
   endtask

   initial begin
      int         w;
      logic [7:0] w1;
      logic [7:0] w2;

      vecs[0] = '{0, 8'hA8, 8'b10101000, 9'b000100000};
      vecs[1] = '{0, 8'h3C, 8'b00111100, 9'b000000000};
      vecs[2] = '{0, 8'h55, 8'b01010101, 9'b101000000};
      vecs[3] = '{1, 8'h15, 8'b10101000, 9'b000000000};
      vecs[4] = '{1, 8'hC1, 8'b10000011, 9'b000000000};
      vecs[5] = '{2, 8'h96, 8'b10010110, 9'b000000000};

      for (int s = 0; s < 3; s++) din_v[s] = 8'h00;
      din_valid_v = 3'b000;

      repeat (3) begin
         @(negedge clk);
         check("ready_in_reset", din_ready_v, 3'b000);
         check("valid_in_reset", d_out_valid_v, 3'b000);
      end
      rst = 1'b1;
      din_v[0] = 8'hA8;
      din_valid_v[0] = 1'b1;
      #1;
      check("ready_after_release", din_ready_v[0], 0);
      check("dout_before_frame", d_out_v[0], 0);
      check("valid_before_frame", d_out_valid_v[0], 0);

      for (int r = 0; r < 6; r++) begin
         run_frame(vecs[r].sel, vecs[r].word, vecs[r].bits, vecs[r].ymask, w);
         if (r == 0) check("accept_second_edge", w, 1);
      end

      // Back-to-back FF then 00 with valid held high.
      din_v[0] = 8'hFF;
      din_valid_v[0] = 1'b1;
      w = 0;
      while (din_ready_v[0] !== 1'b1 && w < 20) begin
         @(negedge clk);
         w = w + 1;
      end
      check("b2b_wait", (w < 20), 1);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 1) din_v[0] = 8'h00;
         check($sformatf("b2b_bit%0d", c), d_out_v[0], (c <= 8));
         check($sformatf("b2b_valid%0d", c), d_out_valid_v[0], 1);
         check($sformatf("b2b_done%0d", c), frame_done_v[0], (c == 8 || c == 16));
         check($sformatf("b2b_ready%0d", c), din_ready_v[0], (c == 8 || c == 16));
         if (c == 16) din_valid_v[0] = 1'b0;
      end
      @(negedge clk);
      check("b2b_end_valid", d_out_valid_v[0], 0);

      // Gap instance: F0 then 0F, valid held until the second accept.
      w1 = 8'hF0;
      w2 = 8'h0F;
      din_v[2] = w1;
      din_valid_v[2] = 1'b1;
      w = 0;
      while (din_ready_v[2] !== 1'b1 && w < 20) begin
         @(negedge clk);
         w = w + 1;
      end
      check("gap_wait", (w < 20), 1);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) din_v[2] = w2;
         check($sformatf("gap_valid%0d", c), d_out_valid_v[2], (c <= 8 || c >= 13));
         check($sformatf("gap_bit%0d", c), d_out_v[2],
               (c <= 8) ? w1[8-c] : ((c >= 13) ? w2[20-c] : 1'b0));
         check($sformatf("gap_ready%0d", c), din_ready_v[2], (c == 12));
         check($sformatf("gap_busy%0d", c), busy_v[2], (c != 12));
         check($sformatf("gap_done%0d", c), frame_done_v[2], (c == 8 || c == 20));
         if (c == 13) din_valid_v[2] = 1'b0;
      end
      @(negedge clk);
      check("gap_end_valid", d_out_valid_v[2], 0);

      // Reset asserted while bit 3 of an FF frame is on the line.
      din_v[0] = 8'hFF;
      din_valid_v[0] = 1'b1;
      w = 0;
      while (din_ready_v[0] !== 1'b1 && w < 20) begin
         @(negedge clk);
         w = w + 1;
      end
      check("midrst_wait", (w < 20), 1);
      repeat (4) @(negedge clk);
      din_valid_v[0] = 1'b0;
      check("midrst_pre_dout", d_out_v[0], 1);
      check("midrst_pre_busy", busy_v[0], 1);
      rst = 1'b0;
      #1;
      check("midrst_dout", d_out_v[0], 0);
      check("midrst_valid", d_out_valid_v[0], 0);
      check("midrst_busy", busy_v[0], 0);
      check("midrst_done", frame_done_v[0], 0);
      repeat (2) begin
         @(negedge clk);
         check("midrst_hold_done", frame_done_v[0], 0);
      end
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check($sformatf("postrst_valid%0d", c), d_out_valid_v[0], 0);
         check($sformatf("postrst_dout%0d", c), d_out_v[0], 0);
         check($sformatf("postrst_busy%0d", c), busy_v[0], 0);
         check($sformatf("postrst_done%0d", c), frame_done_v[0], 0);
      end
      run_frame(0, 8'h5A, 8'b01011010, 9'b000000000, w);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
